// File: rtl/cheri_tbre_mr_if.sv
// LSU port shared between the revocation engine (master) and the load/store unit (slave).
interface cheri_tbre_mr_if;
  logic        lsu_req_o;
  logic        lsu_we_o;
  logic        lsu_is_cap_o;
  logic [31:0] lsu_addr_o;
  logic [32:0] lsu_wdata_o;
  logic        lsu_req_done_i;
  logic        lsu_addr_incr_i;
  logic        lsu_resp_valid_i;
  logic        lsu_resp_err_i;
  logic        lsu_resp_is_wr_i;
  logic [32:0] lsu_raw_lsw_i;

  modport master (
    output lsu_req_o, lsu_we_o, lsu_is_cap_o, lsu_addr_o, lsu_wdata_o,
    input  lsu_req_done_i, lsu_addr_incr_i, lsu_resp_valid_i, lsu_resp_err_i,
           lsu_resp_is_wr_i, lsu_raw_lsw_i
  );

  modport slave (
    input  lsu_req_o, lsu_we_o, lsu_is_cap_o, lsu_addr_o, lsu_wdata_o,
    output lsu_req_done_i, lsu_addr_incr_i, lsu_resp_valid_i, lsu_resp_err_i,
           lsu_resp_is_wr_i, lsu_raw_lsw_i
  );
endinterface

// File: rtl/cheri_tbre_mr.sv
// Multi-region background revocation engine: walks queued ranges granule by granule and
// clears tags of revoked caps. One LSU access in flight; loads throttled at FifoDepth-1 outstanding.
module cheri_tbre_mr #(
  parameter int unsigned NumRegions = 4,
  parameter int unsigned FifoDepth  = 4,
  parameter int unsigned CntW       = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumRegions-1:0]    reg_start_i,
  input  logic [NumRegions*32-1:0] reg_base_i,
  input  logic [NumRegions*32-1:0] reg_end_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic [NumRegions-1:0]    region_done_o,
  output logic [CntW-1:0]          revoke_cnt_o,
  output logic                     err_o,
  input  logic                     snoop_req_done_i,
  input  logic                     snoop_we_i,
  input  logic [31:0]              snoop_addr_i,
  input  logic                     trvk_en_i,
  input  logic                     trvk_clrtag_i,
  cheri_tbre_mr_if.master          lsu
);
  localparam int unsigned IdxW = $clog2(FifoDepth);
  localparam int unsigned PtrW = IdxW + 1;
  localparam int unsigned RegW = (NumRegions > 1) ? $clog2(NumRegions) : 1;

  typedef enum logic [1:0] {Idle, Load, Drain} state_e;
  state_e state_q, state_d;

  logic [NumRegions-1:0] start_q, pending_q, pending_d, start_edge, active_mask, sel_onehot;
  logic [RegW-1:0]       sel_idx, cur_region_q;
  logic [28:0]           cur_addr8_q, end8_q, sel_base8, sel_end8;
  logic                  latch, region_done, wait_q, err_q;
  logic [CntW-1:0]       cnt_q;
  logic [PtrW-1:0]       req_wr_ptr_q, rsp_wr_ptr_q, shd_wr_ptr_q, rd_ptr_q, outstanding;
  logic [FifoDepth-1:0]  a_vld_q, r_err_q, r_tag_q, s_bit_q, snoop_hit;
  logic [28:0]           a_addr8_q [FifoDepth];
  logic [IdxW-1:0]       head;
  logic                  head_ok, store_elig, load_ok, grant, st_grant, ld_grant, pop, rsp_load;
  logic                  unused_sig;

  assign unused_sig = ^{lsu.lsu_raw_lsw_i[31:0], snoop_addr_i[2:0], reg_base_i, reg_end_i};

  assign start_edge  = reg_start_i & ~start_q;
  assign active_mask = (state_q != Idle) ? (NumRegions'(1) << cur_region_q) : '0;

  // Lowest-index pending region wins
  always_comb begin
    sel_idx = '0;
    for (int i = int'(NumRegions) - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = RegW'(i);
    end
  end

  assign sel_base8  = reg_base_i[32*sel_idx+3 +: 29];
  assign sel_end8   = reg_end_i[32*sel_idx+3 +: 29];
  assign sel_onehot = latch ? (NumRegions'(1) << sel_idx) : '0;

  always_comb begin
    pending_d = (pending_q & ~sel_onehot) | (start_edge & ~active_mask & ~pending_q);
    if (abort_i) pending_d = '0;
  end

  assign outstanding = req_wr_ptr_q - rd_ptr_q;
  assign head        = rd_ptr_q[IdxW-1:0];
  assign head_ok     = (req_wr_ptr_q != rd_ptr_q) && (rsp_wr_ptr_q != rd_ptr_q) &&
                       (shd_wr_ptr_q != rd_ptr_q);
  assign store_elig  = head_ok & a_vld_q[head] & r_tag_q[head] & s_bit_q[head] & ~r_err_q[head];
  assign load_ok     = (state_q == Load) & ~abort_i & (outstanding < PtrW'(FifoDepth - 1));

  assign lsu.lsu_req_o    = ~wait_q & (store_elig | load_ok);
  assign lsu.lsu_we_o     = store_elig;
  assign lsu.lsu_is_cap_o = ~store_elig;
  assign lsu.lsu_wdata_o  = '0;
  assign lsu.lsu_addr_o   = store_elig ? {a_addr8_q[head], 3'b000}
                                       : {cur_addr8_q, 3'b000} + (lsu.lsu_addr_incr_i ? 32'd4 : 32'd0);

  assign grant    = lsu.lsu_req_done_i & lsu.lsu_req_o;
  assign st_grant = grant & store_elig;
  assign ld_grant = grant & ~store_elig;
  assign pop      = st_grant | (head_ok & ~store_elig);
  assign rsp_load = lsu.lsu_resp_valid_i & ~lsu.lsu_resp_is_wr_i;

  always_comb begin
    for (int i = 0; i < int'(FifoDepth); i++) begin
      snoop_hit[i] = snoop_req_done_i & snoop_we_i & (snoop_addr_i[31:3] == a_addr8_q[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    latch       = 1'b0;
    region_done = 1'b0;
    unique case (state_q)
      Idle: begin
        if (pending_q != '0 && !abort_i) begin
          latch   = 1'b1;
          state_d = (sel_base8 > sel_end8) ? Drain : Load;
        end
      end
      Load: begin
        if (abort_i || (ld_grant && cur_addr8_q == end8_q)) state_d = Drain;
      end
      Drain: begin
        if (outstanding == '0) begin
          region_done = 1'b1;
          if (pending_q != '0 && !abort_i) begin
            latch   = 1'b1;
            state_d = (sel_base8 > sel_end8) ? Drain : Load;
          end else begin
            state_d = Idle;
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= Idle;
      start_q      <= '0;
      pending_q    <= '0;
      cur_region_q <= '0;
      cur_addr8_q  <= '0;
      end8_q       <= '0;
      wait_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= reg_start_i;
      pending_q <= pending_d;
      if (latch) begin
        cur_region_q <= sel_idx;
        cur_addr8_q  <= sel_base8;
        end8_q       <= sel_end8;
      end else if (ld_grant) begin
        cur_addr8_q <= cur_addr8_q + 29'd1;
      end
      // Response clears first so a zero-latency LSU cannot wedge the flag
      wait_q <= (wait_q | grant) & ~lsu.lsu_resp_valid_i;
      if (pop && r_err_q[head]) err_q <= 1'b1;
      else if (state_q == Idle && start_edge != '0) err_q <= 1'b0;
      if (st_grant && cnt_q != '1) cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Snoop clears come first so a same-cycle load write to that slot wins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_vld_q      <= '0;
      r_err_q      <= '0;
      r_tag_q      <= '0;
      s_bit_q      <= '0;
      req_wr_ptr_q <= '0;
      rsp_wr_ptr_q <= '0;
      shd_wr_ptr_q <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < int'(FifoDepth); i++) a_addr8_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        if (snoop_hit[i]) a_vld_q[i] <= 1'b0;
      end
      if (ld_grant) begin
        a_vld_q[req_wr_ptr_q[IdxW-1:0]]   <= 1'b1;
        a_addr8_q[req_wr_ptr_q[IdxW-1:0]] <= cur_addr8_q;
        req_wr_ptr_q                      <= req_wr_ptr_q + PtrW'(1);
      end
      if (rsp_load) begin
        r_err_q[rsp_wr_ptr_q[IdxW-1:0]] <= lsu.lsu_resp_err_i;
        r_tag_q[rsp_wr_ptr_q[IdxW-1:0]] <= lsu.lsu_raw_lsw_i[32];
        rsp_wr_ptr_q                    <= rsp_wr_ptr_q + PtrW'(1);
      end
      if (trvk_en_i) begin
        s_bit_q[shd_wr_ptr_q[IdxW-1:0]] <= trvk_clrtag_i;
        shd_wr_ptr_q                    <= shd_wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  assign busy_o        = (state_q != Idle);
  assign region_done_o = region_done ? (NumRegions'(1) << cur_region_q) : '0;
  assign revoke_cnt_o  = cnt_q;
  assign err_o         = err_q;
endmodule
